// File: rtl/dwc_pkg.sv
// Shared types and constants for the lockstep AXI4-Lite arbiter.
// Request capture, comparison and FSM logic all import this package.
package dwc_pkg;

    localparam int DWC_ADDR_W = 32;
    localparam int DWC_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT2,
        CMP,
        M_AW,
        M_B,
        M_AR,
        M_R,
        RESP
    } fsm_t;

    typedef enum logic {
        KIND_READ  = 1'b0,
        KIND_WRITE = 1'b1
    } kind_t;

    typedef struct packed {
        kind_t                   kind;
        logic [DWC_ADDR_W-1:0]   addr;
        logic [DWC_DATA_W-1:0]   data;
        logic [DWC_DATA_W/8-1:0] strb;
    } dwc_req_t;

    // Data and strobe only matter for writes; reads carry zeros there.
    function automatic logic req_match(input dwc_req_t a, input dwc_req_t b);
        if ((a.kind != b.kind) || (a.addr != b.addr)) begin
            return 1'b0;
        end
        if (a.kind == KIND_WRITE) begin
            return (a.data == b.data) && (a.strb == b.strb);
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/dwc_core_capture.sv
// Per-core request capture: accepts one write (AW+W together) or one read
// per transaction and holds it until the arbiter releases it with clear_i.
module dwc_core_capture
    import dwc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    clear_i,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DWC_ADDR_W-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DWC_DATA_W-1:0]   wdata,
    input  logic [DWC_DATA_W/8-1:0] wstrb,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [DWC_ADDR_W-1:0]   araddr,
    output logic                    take_o,
    output logic                    captured_o,
    output dwc_req_t                req_o
);

    logic wr_take;
    logic rd_take;

    // Write wins whenever both AW and W are present; a read is only taken otherwise.
    assign wr_take = en_i && !captured_o && awvalid && wvalid;
    assign rd_take = en_i && !captured_o && arvalid && !(awvalid && wvalid);

    assign awready = wr_take;
    assign wready  = wr_take;
    assign arready = rd_take;
    assign take_o  = wr_take || rd_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured_o <= 1'b0;
            req_o      <= '0;
        end else if (clear_i) begin
            captured_o <= 1'b0;
        end else if (wr_take) begin
            captured_o <= 1'b1;
            req_o      <= '{kind: KIND_WRITE, addr: awaddr, data: wdata, strb: wstrb};
        end else if (rd_take) begin
            captured_o <= 1'b1;
            req_o      <= '{kind: KIND_READ, addr: araddr, data: '0, strb: '0};
        end
    end

endmodule

// File: rtl/dwc_lockstep_axil_arbiter.sv
// Lockstep AXI4-Lite arbiter: forwards a request downstream only when both
// cores issued the identical request, and fans the single response back out.
module dwc_lockstep_axil_arbiter
    import dwc_pkg::*;
#(
    parameter int ADDR_W      = DWC_ADDR_W,
    parameter int DATA_W      = DWC_DATA_W,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // All channels: a beat transfers on a cycle where valid && ready; a valid,
    // once raised, is held with stable payload until its ready is seen.
    input  logic                s0_awvalid,
    output logic                s0_awready,
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic                s0_wvalid,
    output logic                s0_wready,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    output logic [1:0]          s0_bresp,
    input  logic                s0_arvalid,
    output logic                s0_arready,
    input  logic [ADDR_W-1:0]   s0_araddr,
    output logic                s0_rvalid,
    input  logic                s0_rready,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic [1:0]          s0_rresp,
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    output logic [1:0]          s1_bresp,
    input  logic                s1_arvalid,
    output logic                s1_arready,
    input  logic [ADDR_W-1:0]   s1_araddr,
    output logic                s1_rvalid,
    input  logic                s1_rready,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic [1:0]          s1_rresp,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    output logic                mismatch_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output fsm_t                dbg_state
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

    fsm_t              state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q;
    logic [1:0]        resp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done0_q, done1_q;
    logic              aw_done_q, w_done_q;
    logic              cap_en, clear;
    logic              take0, take1, cap0, cap1;
    dwc_req_t          req0, req1;
    logic              s0_hs, s1_hs, fin0, fin1;

    assign cap_en    = (state_q == IDLE) || (state_q == WAIT2);
    assign dbg_state = state_q;

    dwc_core_capture u_cap0 (
        .clk        (ACLK),
        .rst        (ARESET),
        .en_i       (cap_en),
        .clear_i    (clear),
        .awvalid    (s0_awvalid),
        .awready    (s0_awready),
        .awaddr     (s0_awaddr),
        .wvalid     (s0_wvalid),
        .wready     (s0_wready),
        .wdata      (s0_wdata),
        .wstrb      (s0_wstrb),
        .arvalid    (s0_arvalid),
        .arready    (s0_arready),
        .araddr     (s0_araddr),
        .take_o     (take0),
        .captured_o (cap0),
        .req_o      (req0)
    );

    dwc_core_capture u_cap1 (
        .clk        (ACLK),
        .rst        (ARESET),
        .en_i       (cap_en),
        .clear_i    (clear),
        .awvalid    (s1_awvalid),
        .awready    (s1_awready),
        .awaddr     (s1_awaddr),
        .wvalid     (s1_wvalid),
        .wready     (s1_wready),
        .wdata      (s1_wdata),
        .wstrb      (s1_wstrb),
        .arvalid    (s1_arvalid),
        .arready    (s1_arready),
        .araddr     (s1_araddr),
        .take_o     (take1),
        .captured_o (cap1),
        .req_o      (req1)
    );

    // Only captured cores participate in the response; the absent core after a timeout gets nothing.
    assign s0_bvalid = (state_q == RESP) && cap0 && !done0_q && (req0.kind == KIND_WRITE);
    assign s0_rvalid = (state_q == RESP) && cap0 && !done0_q && (req0.kind == KIND_READ);
    assign s1_bvalid = (state_q == RESP) && cap1 && !done1_q && (req1.kind == KIND_WRITE);
    assign s1_rvalid = (state_q == RESP) && cap1 && !done1_q && (req1.kind == KIND_READ);
    assign s0_bresp  = resp_q;
    assign s0_rresp  = resp_q;
    assign s0_rdata  = rdata_q;
    assign s1_bresp  = resp_q;
    assign s1_rresp  = resp_q;
    assign s1_rdata  = rdata_q;

    assign s0_hs = (s0_bvalid && s0_bready) || (s0_rvalid && s0_rready);
    assign s1_hs = (s1_bvalid && s1_bready) || (s1_rvalid && s1_rready);
    assign fin0  = !cap0 || done0_q || s0_hs;
    assign fin1  = !cap1 || done1_q || s1_hs;

    // Both cores agreed, so core 0's captured request is the forwarded payload.
    assign m_awvalid = (state_q == M_AW) && !aw_done_q;
    assign m_wvalid  = (state_q == M_AW) && !w_done_q;
    assign m_awaddr  = req0.addr;
    assign m_wdata   = req0.data;
    assign m_wstrb   = req0.strb;
    assign m_bready  = (state_q == M_B);
    assign m_arvalid = (state_q == M_AR);
    assign m_araddr  = req0.addr;
    assign m_rready  = (state_q == M_R);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mismatch_o = 1'b0;
        timeout_o  = 1'b0;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                if (take0 && take1) begin
                    state_d = CMP;
                end else if (take0 || take1) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if ((cap0 || take0) && (cap1 || take1)) begin
                    state_d = CMP;
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_o = 1'b1;
                    state_d   = RESP;
                end
            end
            CMP: begin
                if (req_match(req0, req1)) begin
                    state_d = (req0.kind == KIND_WRITE) ? M_AW : M_AR;
                end else begin
                    mismatch_o = 1'b1;
                    state_d    = RESP;
                end
            end
            M_AW: begin
                if ((aw_done_q || m_awready) && (w_done_q || m_wready)) begin
                    state_d = M_B;
                end
            end
            M_B: begin
                if (m_bvalid) begin
                    state_d = RESP;
                end
            end
            M_AR: begin
                if (m_arready) begin
                    state_d = M_R;
                end
            end
            M_R: begin
                if (m_rvalid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (fin0 && fin1) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tcnt_q    <= '0;
            resp_q    <= RESP_OKAY;
            rdata_q   <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            tcnt_q    <= (state_q == WAIT2) ? tcnt_q + TCNT_W'(1) : '0;
            aw_done_q <= (state_q == M_AW) && (aw_done_q || m_awready);
            w_done_q  <= (state_q == M_AW) && (w_done_q || m_wready);
            done0_q   <= (state_q == RESP) && (done0_q || s0_hs);
            done1_q   <= (state_q == RESP) && (done1_q || s1_hs);
            if (mismatch_o || timeout_o) begin
                resp_q  <= RESP_SLVERR;
                rdata_q <= '0;
            end else if ((state_q == M_B) && m_bvalid) begin
                resp_q <= m_bresp;
            end else if ((state_q == M_R) && m_rvalid) begin
                resp_q  <= m_rresp;
                rdata_q <= m_rdata;
            end
            if ((mismatch_o || timeout_o) && (err_cnt_o != {CNT_W{1'b1}})) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dwc_lockstep_axil_arbiter.sv
// Directed bench for the lockstep arbiter: zero-wait downstream slave model,
// handshake monitor feeding got-queues, and expected queues filled at drive time.
module tb_dwc_lockstep_axil_arbiter;
    import dwc_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [3:0]  s0_wstrb;
    logic [1:0]  s0_bresp, s0_rresp;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
    logic [3:0]  s1_wstrb;
    logic [1:0]  s1_bresp, s1_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        mismatch_o, timeout_o;
    logic [15:0] err_cnt_o;
    fsm_t        dbg_state;

    dwc_lockstep_axil_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .ACLK(clk), .ARESET(rst),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .mismatch_o(mismatch_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Downstream slave: always ready, B/R one cycle after the request beat (B optionally delayed).
    int          b_delay = 0;
    int          b_cnt;
    logic        b_pend;
    logic [31:0] slave_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bvalid <= 1'b0;
            m_bresp  <= RESP_OKAY;
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
            m_rresp  <= RESP_OKAY;
            b_pend   <= 1'b0;
            b_cnt    <= 0;
        end else begin
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_wvalid && m_wready) begin
                if (b_delay == 0) begin
                    m_bvalid <= 1'b1;
                end else begin
                    b_pend <= 1'b1;
                    b_cnt  <= b_delay - 1;
                end
            end else if (b_pend) begin
                if (b_cnt == 0) begin
                    m_bvalid <= 1'b1;
                    b_pend   <= 1'b0;
                end else begin
                    b_cnt <= b_cnt - 1;
                end
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= slave_rdata;
            end
        end
    end

    // Scoreboard queues: core response {is_read, resp, data}; downstream beat {is_write, addr, data, strb}.
    logic [34:0] exp0_q[$], exp1_q[$], got0_q[$], got1_q[$];
    logic [68:0] exp_m_q[$], got_m_q[$];
    int cyc = 0;
    int cap0_cyc, aw_cyc, mb_cyc, s0_bh_cyc, to_cyc;
    int aw_cnt = 0, ar_cnt = 0, mism_cnt = 0, to_cnt = 0, s1_rv_cnt = 0;
    int checks = 0, failures = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if ((s0_awvalid && s0_awready) || (s0_arvalid && s0_arready)) cap0_cyc <= cyc;
            if (m_awvalid && m_awready) begin
                got_m_q.push_back({1'b1, m_awaddr, m_wdata, m_wstrb});
                aw_cnt <= aw_cnt + 1;
                aw_cyc <= cyc;
            end
            if (m_arvalid && m_arready) begin
                got_m_q.push_back({1'b0, m_araddr, 32'h0, 4'h0});
                ar_cnt <= ar_cnt + 1;
            end
            if (m_bvalid && m_bready) mb_cyc <= cyc;
            if (s0_bvalid && s0_bready) begin
                got0_q.push_back({1'b0, s0_bresp, 32'h0});
                s0_bh_cyc <= cyc;
            end
            if (s0_rvalid && s0_rready) got0_q.push_back({1'b1, s0_rresp, s0_rdata});
            if (s1_bvalid && s1_bready) got1_q.push_back({1'b0, s1_bresp, 32'h0});
            if (s1_rvalid && s1_rready) got1_q.push_back({1'b1, s1_rresp, s1_rdata});
            if (s1_rvalid) s1_rv_cnt <= s1_rv_cnt + 1;
            if (mismatch_o) mism_cnt <= mism_cnt + 1;
            if (timeout_o) begin
                to_cnt <= to_cnt + 1;
                to_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request per selected core; each core drops its valids after its own handshake.
    task automatic send(input bit u0, input bit u1,
                        input bit w0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] st0,
                        input bit w1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] st1);
        bit p0, p1, h0, h1;
        @(negedge clk);
        if (u0) begin
            s0_awvalid = w0; s0_wvalid = w0; s0_arvalid = !w0;
            s0_awaddr = a0; s0_wdata = d0; s0_wstrb = st0; s0_araddr = a0;
        end
        if (u1) begin
            s1_awvalid = w1; s1_wvalid = w1; s1_arvalid = !w1;
            s1_awaddr = a1; s1_wdata = d1; s1_wstrb = st1; s1_araddr = a1;
        end
        p0 = u0;
        p1 = u1;
        for (int i = 0; i < 20 && (p0 || p1); i++) begin
            #1;
            h0 = p0 && (s0_awready || s0_arready);
            h1 = p1 && (s1_awready || s1_arready);
            @(negedge clk);
            if (h0) begin
                s0_awvalid = 1'b0; s0_wvalid = 1'b0; s0_arvalid = 1'b0; p0 = 1'b0;
            end
            if (h1) begin
                s1_awvalid = 1'b0; s1_wvalid = 1'b0; s1_arvalid = 1'b0; p1 = 1'b0;
            end
        end
        chk("send_accepted", 69'({p0, p1}), 69'd0);
    endtask

    task automatic pop_resp(input int core, input string tag);
        logic [34:0] g, e;
        int n = 0;
        while (((core == 0) ? got0_q.size() : got1_q.size()) == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrive"}, 69'(((core == 0) ? got0_q.size() : got1_q.size()) > 0), 69'd1);
        if (((core == 0) ? got0_q.size() : got1_q.size()) > 0) begin
            if (core == 0) begin
                g = got0_q.pop_front();
                e = exp0_q.pop_front();
            end else begin
                g = got1_q.pop_front();
                e = exp1_q.pop_front();
            end
            chk(tag, 69'(g), 69'(e));
        end
    endtask

    task automatic pop_m(input string tag);
        logic [68:0] g, e;
        int n = 0;
        while (got_m_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrive"}, 69'(got_m_q.size() > 0), 69'd1);
        if (got_m_q.size() > 0) begin
            g = got_m_q.pop_front();
            e = exp_m_q.pop_front();
            chk(tag, g, e);
        end
    endtask

    int before_a, before_b, before_c;

    initial begin
        rst = 1'b1;
        s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0; s0_awaddr = 0; s0_wdata = 0; s0_wstrb = 0; s0_araddr = 0;
        s1_awvalid = 0; s1_wvalid = 0; s1_arvalid = 0; s1_awaddr = 0; s1_wdata = 0; s1_wstrb = 0; s1_araddr = 0;
        s0_bready = 1; s0_rready = 1; s1_bready = 1; s1_rready = 1;
        m_awready = 1; m_wready = 1; m_arready = 1;
        slave_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", 69'(dbg_state), 69'(IDLE));
        chk("rst_valids", 69'({s0_awready, s0_wready, s0_arready, s1_awready, s1_arready, s0_bvalid, s0_rvalid,
                               s1_bvalid, s1_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 69'd0);
        chk("rst_payload", 69'({m_awaddr, m_wdata}), 69'd0);
        chk("rst_pulses_cnt", 69'({mismatch_o, timeout_o, err_cnt_o}), 69'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Matched write, both cores aligned
        exp_m_q.push_back({1'b1, 32'h4, 32'h2, 4'hF});
        exp0_q.push_back({1'b0, RESP_OKAY, 32'h0});
        exp1_q.push_back({1'b0, RESP_OKAY, 32'h0});
        send(1, 1, 1, 32'h4, 32'h2, 4'hF, 1, 32'h4, 32'h2, 4'hF);
        pop_m("wr_beat");
        pop_resp(0, "wr_s0");
        pop_resp(1, "wr_s1");
        chk("wr_aw_latency", 69'(aw_cyc - cap0_cyc), 69'd2);
        chk("wr_b_latency", 69'(s0_bh_cyc - mb_cyc), 69'd1);
        chk("wr_err_cnt", 69'(err_cnt_o), 69'd0);
        chk("wr_aw_count", 69'(aw_cnt), 69'd1);

        // Data mismatch
        before_a = mism_cnt;
        exp0_q.push_back({1'b0, RESP_SLVERR, 32'h0});
        exp1_q.push_back({1'b0, RESP_SLVERR, 32'h0});
        send(1, 1, 1, 32'h8, 32'h3, 4'hF, 1, 32'h8, 32'h7, 4'hF);
        pop_resp(0, "mm_s0");
        pop_resp(1, "mm_s1");
        chk("mm_no_aw", 69'(aw_cnt), 69'd1);
        chk("mm_pulse", 69'(mism_cnt - before_a), 69'd1);
        chk("mm_err_cnt", 69'(err_cnt_o), 69'd1);

        // Read with S1 ten cycles late
        slave_rdata = 32'h4;
        exp_m_q.push_back({1'b0, 32'hC, 32'h0, 4'h0});
        exp0_q.push_back({1'b1, RESP_OKAY, 32'h4});
        exp1_q.push_back({1'b1, RESP_OKAY, 32'h4});
        send(1, 0, 0, 32'hC, 32'h0, 4'h0, 0, 32'h0, 32'h0, 4'h0);
        repeat (10) @(negedge clk);
        chk("rd_wait2", 69'(dbg_state), 69'(WAIT2));
        send(0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 32'hC, 32'h0, 4'h0);
        pop_m("rd_beat");
        pop_resp(0, "rd_s0");
        pop_resp(1, "rd_s1");
        chk("rd_ar_count", 69'(ar_cnt), 69'd1);

        // One-sided read: timeout
        before_a = to_cnt;
        before_b = ar_cnt;
        before_c = s1_rv_cnt;
        exp0_q.push_back({1'b1, RESP_SLVERR, 32'h0});
        send(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 4'h0);
        pop_resp(0, "to_s0");
        chk("to_latency", 69'(to_cyc - cap0_cyc), 69'(TO));
        chk("to_pulse", 69'(to_cnt - before_a), 69'd1);
        chk("to_err_cnt", 69'(err_cnt_o), 69'd2);
        chk("to_no_ar", 69'(ar_cnt - before_b), 69'd0);
        repeat (5) @(negedge clk);
        chk("to_s1_silent", 69'({s1_rv_cnt - before_c, got1_q.size()}), 69'd0);

        // Backpressure on S0 response
        s0_bready = 1'b0;
        exp_m_q.push_back({1'b1, 32'h10, 32'h55, 4'hF});
        exp0_q.push_back({1'b0, RESP_OKAY, 32'h0});
        exp1_q.push_back({1'b0, RESP_OKAY, 32'h0});
        send(1, 1, 1, 32'h10, 32'h55, 4'hF, 1, 32'h10, 32'h55, 4'hF);
        pop_m("bp_beat");
        pop_resp(1, "bp_s1");
        repeat (5) @(negedge clk);
        chk("bp_s0_pending", 69'(got0_q.size()), 69'd0);
        chk("bp_hold_resp", 69'(dbg_state), 69'(RESP));
        chk("bp_s0_bvalid", 69'(s0_bvalid), 69'd1);
        s0_bready = 1'b1;
        pop_resp(0, "bp_s0");
        exp_m_q.push_back({1'b1, 32'h14, 32'h66, 4'h3});
        exp0_q.push_back({1'b0, RESP_OKAY, 32'h0});
        exp1_q.push_back({1'b0, RESP_OKAY, 32'h0});
        send(1, 1, 1, 32'h14, 32'h66, 4'h3, 1, 32'h14, 32'h66, 4'h3);
        pop_m("bp_next_beat");
        pop_resp(0, "bp_next_s0");
        pop_resp(1, "bp_next_s1");

        // Reset while waiting for B
        b_delay = 10;
        exp_m_q.push_back({1'b1, 32'h20, 32'h9, 4'hF});
        send(1, 1, 1, 32'h20, 32'h9, 4'hF, 1, 32'h20, 32'h9, 4'hF);
        pop_m("rs_beat");
        for (int i = 0; i < 50 && dbg_state != M_B; i++) @(negedge clk);
        chk("rs_in_m_b", 69'(dbg_state), 69'(M_B));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs_valids", 69'({s0_bvalid, s1_bvalid, s0_rvalid, s1_rvalid, m_awvalid, m_wvalid, m_arvalid,
                              m_bready, m_rready}), 69'd0);
        chk("rs_err_cnt", 69'(err_cnt_o), 69'd0);
        chk("rs_state", 69'(dbg_state), 69'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        b_delay = 0;
        repeat (3) @(negedge clk);
        chk("rs_no_orphan", 69'({got0_q.size(), got1_q.size()}), 69'd0);
        exp_m_q.push_back({1'b1, 32'h24, 32'hA, 4'hF});
        exp0_q.push_back({1'b0, RESP_OKAY, 32'h0});
        exp1_q.push_back({1'b0, RESP_OKAY, 32'h0});
        send(1, 1, 1, 32'h24, 32'hA, 4'hF, 1, 32'h24, 32'hA, 4'hF);
        pop_m("rs_after_beat");
        pop_resp(0, "rs_after_s0");
        pop_resp(1, "rs_after_s1");

        repeat (3) @(negedge clk);
        chk("exp_drained", 69'(exp0_q.size() + exp1_q.size() + exp_m_q.size()), 69'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
